// File: rtl/apb_master_bridge.sv
// APB requester bridging a command/response port onto the SPI peripheral's
// APB register interface. One transfer outstanding; stalled ACCESS phases
// are aborted after a programmable number of wait cycles.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  // Counter value seen on the last permitted stalled ACCESS cycle.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [TO_W-1:0]   cnt, cnt_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt, busy_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              timeout_hit;

  assign cmd_ready   = (state == ST_IDLE);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt   = ST_SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_write ? cmd_wdata : '0;
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_nxt       = ST_IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
        end else if (timeout_hit) begin
          state_nxt       = ST_IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State register and registered APB / response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: table of single transfers with a
// response scoreboard, plus back-to-back and mid-transfer reset sequences.
module tb_apb_master_bridge;

  localparam int unsigned TIMEOUT = 15;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    int unsigned waits;
    logic [7:0]  prdata;
    bit          slverr;
    logic [7:0]  e_rdata;
    bit          e_err;
    bit          e_to;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    bit         err;
    bit         to;
  } rsp_t;

  rsp_t exp_q[$];
  vec_t vecs[9];

  apb_master_bridge #(
    .ADDR_W (3),
    .DATA_W (8),
    .TIMEOUT(TIMEOUT),
    .TO_W   (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    rsp_t e;
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"},   rsp_rdata,   e.rdata);
      check({tag, "_err"},     rsp_err,     e.err);
      check({tag, "_timeout"}, rsp_timeout, e.to);
    end
  endtask

  // Entered and left at posedge+1 with the bridge idle.
  task automatic run_vec(input vec_t v, input int idx);
    rsp_t        e;
    bit          done;
    int unsigned k, n, exp_cyc;
    string       tag;
    tag = $sformatf("v%0d", idx);
    n = (v.waits < TIMEOUT) ? v.waits + 1 : TIMEOUT;
    exp_cyc = 2 + n;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    e.rdata = v.e_rdata;
    e.err   = v.e_err;
    e.to    = v.e_to;
    exp_q.push_back(e);
    done = 1'b0;
    for (int unsigned cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge PCLK); #1;
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        check({tag, "_setup_psel"},    PSEL,    1);
        check({tag, "_setup_penable"}, PENABLE, 0);
        check({tag, "_setup_busy"},    busy,    1);
        check({tag, "_paddr"},         PADDR,   v.addr);
        check({tag, "_pwrite"},        PWRITE,  v.wr);
        check({tag, "_pwdata"},        PWDATA,  v.wr ? v.wdata : 8'h00);
        // Junk outside ACCESS must be ignored.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 8'hFF;
      end else if (rsp_valid) begin
        done = 1'b1;
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_rsp_psel"}, PSEL, 0);
        check({tag, "_rsp_penable"}, PENABLE, 0);
        pop_compare(tag);
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else begin
        k = cyc - 2;
        check({tag, "_acc_psel_penable"}, {PSEL, PENABLE}, 2'b11);
        check({tag, "_acc_paddr_stable"}, PADDR, v.addr);
        check({tag, "_acc_pwdata_stable"}, PWDATA, v.wr ? v.wdata : 8'h00);
        if (k == v.waits) begin
          PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
        end else begin
          PREADY = 1'b0; PRDATA = ~v.prdata; PSLVERR = 1'b1;
        end
      end
    end
    if (!done) check({tag, "_rsp_seen"}, 0, 1);
    @(posedge PCLK); #1;
    check({tag, "_pulse_single"}, rsp_valid, 0);
    check({tag, "_rdata_hold"},   rsp_rdata, v.e_rdata);
    check({tag, "_err_hold"},     rsp_err,   v.e_err);
  endtask

  initial begin
    rsp_t e;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    //         wr addr wdata  waits prdata slv  e_rdata e_err e_to
    vecs[0] = '{1, 3'd0, 8'h5C, 0,  8'h00, 0, 8'h00, 0, 0};
    vecs[1] = '{0, 3'd5, 8'h11, 3,  8'hA7, 0, 8'hA7, 0, 0};
    vecs[2] = '{1, 3'd5, 8'h3C, 2,  8'h00, 1, 8'h00, 1, 0};
    vecs[3] = '{0, 3'd1, 8'h77, 0,  8'h42, 0, 8'h42, 0, 0};
    vecs[4] = '{0, 3'd2, 8'h00, 99, 8'h66, 0, 8'h00, 1, 1};
    vecs[5] = '{0, 3'd5, 8'h00, 14, 8'h99, 0, 8'h99, 0, 0};
    vecs[6] = '{1, 3'd2, 8'hC3, 13, 8'h55, 0, 8'h00, 0, 0};
    vecs[7] = '{0, 3'd0, 8'h00, 1,  8'h81, 1, 8'h81, 1, 0};
    vecs[8] = '{1, 3'd1, 8'hFF, 99, 8'h00, 0, 8'h00, 1, 1};

    #12;
    check("reset_outputs",
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy},
          '0);
    check("reset_cmd_ready", cmd_ready, 1);
    #10 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back: cmd_valid held for three writes, PREADY tied high.
    PREADY = 1'b1; PSLVERR = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 8'h10;
    for (int n = 0; n < 3; n++) begin
      e.rdata = 8'h00; e.err = 1'b0; e.to = 1'b0;
      exp_q.push_back(e);
    end
    begin
      int pulses;
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge PCLK); #1;
        check($sformatf("b2b_psel_c%0d", c), PSEL, (c <= 9) && (c % 3 != 0));
        check($sformatf("b2b_penable_c%0d", c), PENABLE, (c <= 9) && (c % 3 == 2));
        if (rsp_valid) begin
          pulses++;
          check($sformatf("b2b_rsp_cycle_c%0d", c), c % 3, 0);
          pop_compare("b2b");
        end
        if (c <= 9 && c % 3 == 1) begin
          check($sformatf("b2b_pwdata_c%0d", c), PWDATA, 8'h10 + 8'(c / 3));
          cmd_wdata = 8'h10 + 8'(c / 3) + 8'h01;
          if (c == 7) cmd_valid = 1'b0;
        end
      end
      check("b2b_pulse_count", pulses, 3);
    end
    PREADY = 1'b0;

    // Reset during ACCESS: bus drops immediately, no response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd5;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    check("rst_mid_penable_before", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("rst_mid_async_bus", {PSEL, PENABLE, busy, rsp_valid}, 4'b0000);
    check("rst_mid_async_paddr", PADDR, 0);
    cmd_valid = 1'b1; PREADY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge PCLK); #1;
      check("rst_cmd_ignored", {PSEL, rsp_valid, busy}, 3'b000);
    end
    cmd_valid = 1'b0; PREADY = 1'b0;
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("rst_after_no_rsp", rsp_valid, 0);
    check("rst_after_sb_empty", exp_q.size(), 0);
    run_vec('{0, 3'd5, 8'h00, 1, 8'h3E, 0, 8'h3E, 0, 0}, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
